fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle instruction-fetch controller that owns the program counter for the processor core.
- Issues requests to a variable-latency instruction memory and holds each fetched instruction for the decode stage.
- On each handshake with decode, computes the next PC from the sequential, branch and jump controls that decode returns.
- Sits between instruction memory and decode/control. Detects stalled memory via a timeout and counts retired instructions.

Parameters:
- RESET_VECTOR, 32'h0000_0000, byte address of the first fetch after reset.
- TIMEOUT, 255, maximum cycles in REQ without an acknowledge before error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low (0 = reset).
- imem_req  output  1  fetch request, high only in REQ.
- imem_addr  output  32  current PC (byte address), stable while imem_req is high.
- imem_ack  input  1  memory has data; sampled on the clk edge while in REQ.
- imem_rdata  input  32  instruction word, valid when imem_ack is high.
- instr  output  32  latched instruction.
- instr_valid  output  1  instr holds an unconsumed instruction.
- instr_ready  input  1  decode accepts instr.
- Branch  input  1  accepted instruction is a branch.
- Zero  input  1  ALU zero flag for the accepted instruction.
- Jump  input  1  accepted instruction is a jump.
- const  input  16  branch offset in words, signed.
- address  input  26  jump target field.
- pc  output  32  PC of the instruction in instr; equals imem_addr.
- retire_count  output  32  number of accepted instructions.
- fetch_err  output  1  sticky timeout error.

Behaviour:
- Reset (reset = 0, any time, asynchronous):
  - state = IDLE, pc = RESET_VECTOR, instr = 0, timeout counter = 0, retire_count = 0, fetch_err = 0.
  - All outputs take these values immediately. An in-flight request is abandoned; a late imem_ack is ignored.
- States: IDLE, REQ, HOLD, ERR.
- IDLE: outputs idle. Moves to REQ on the first clk edge after reset is released.
- REQ:
  - imem_req = 1, imem_addr = pc.
  - On an edge with imem_ack = 1: instr <= imem_rdata, counter <= 0, go to HOLD.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT - 1 without an ack, fetch_err <= 1 and go to ERR on that edge. The request therefore lasts at most TIMEOUT cycles.
- HOLD:
  - instr_valid = 1; imem_req = 0.
  - On an edge with instr_ready = 1 (accept):
    - retire_count increments; it wraps 0xFFFF_FFFF -> 0.
    - pc <= next_pc, then go to REQ.
  - Without instr_ready, hold indefinitely with instr and pc stable.
- next_pc, evaluated on the accept edge using the control inputs present in that cycle:
  - pc4 = pc + 4, modulo 2^32 (0xFFFF_FFFC -> 0).
  - If Branch & Zero: pc4 + (sign_extend(const) << 2), modulo 2^32.
  - Else if Jump: {pc4[31:28], address, 2'b00}.
  - Else: pc4.
  - Branch-taken has priority over Jump when both are asserted.
- Control inputs are don't-care outside the accept cycle.
- ERR:
  - imem_req = 0, instr_valid = 0, fetch_err = 1. pc holds the faulting address.
  - Left only by reset.
- Latency: ack in the first REQ cycle and ready in the first HOLD cycle gives one instruction every 2 cycles. The first request is issued 1 cycle after reset release.
- imem_addr and pc are always word-aligned when RESET_VECTOR is word-aligned.

Decomposition:
- Shared package (cpu_pkg): state enum (IDLE/REQ/HOLD/ERR), PC_INC = 4, opcode/field width constants (ADDR_W = 26, IMM_W = 16).
- One natural sub-module: next_pc_calc, a combinational target mux.
  - Inputs: pc, Branch, Zero, Jump, const, address.
  - Output: next_pc.
  - Reused by any later pipelined core.

Test Plan:
- Sequential fetch with RESET_VECTOR = 0, ack after 0 cycles, ready always 1, no Branch/Jump -> imem_addr sequence 0, 4, 8, 12; one instr_valid every 2 cycles; retire_count = 4 after 4 accepts.
- Branch taken at pc = 0x100, const = 16'hFFFE, Zero = 1 -> next imem_addr 0xFC. With Zero = 0 -> 0x104.
- Jump at pc = 0x3000_0010, address = 26'h000_0040 -> next imem_addr 0x3000_0100. With Branch = Zero = Jump = 1 and const = 1 -> 0x3000_0018 (branch wins).
- Back-pressure: instr_ready low for 5 cycles in HOLD -> instr, pc and instr_valid stable; no imem_req. Ready high -> single retire and a single next request.
- Timeout with TIMEOUT = 4, imem_ack stuck 0 -> exactly 4 REQ cycles; fetch_err = 1 and imem_req = 0 from the next cycle, persisting. A late ack is ignored. Reset low -> fetch_err = 0, pc = RESET_VECTOR.
- Wrap and reset mid-operation: RESET_VECTOR = 0xFFFF_FFFC, one accept -> imem_addr 0x0. Assert reset during REQ with ack arriving the same cycle -> instr = 0, instr_valid = 0, pc = RESET_VECTOR, retire_count = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch state encoding and instruction field widths
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} fetch_state_t;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam int ADDR_W = 26;
  localparam int IMM_W = 16;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: sequential / branch / jump target mux, branch-taken wins over jump
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] address,
  output logic [31:0]       next_pc
);
  logic [31:0] pc4, br_tgt, j_tgt;
  always_comb begin
    pc4 = pc + PC_INC;
    br_tgt = pc4 + {{(32-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    j_tgt = {pc4[31:28], address, 2'b00};
    next_pc = (Branch && Zero) ? br_tgt : Jump ? j_tgt : pc4;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner issuing variable-latency fetches, holding instr for decode, with timeout
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 255,
  parameter int          CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              Branch,
  input  logic              Zero,
  input  logic              Jump,
  input  logic [IMM_W-1:0]  const_imm,
  input  logic [ADDR_W-1:0] address,
  output logic [31:0]       pc,
  output logic [31:0]       retire_count,
  output logic              fetch_err
);
  fetch_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0] next_pc;
  logic timed_out;
  next_pc_calc u_next_pc (
    .pc      (pc),
    .Branch  (Branch),
    .Zero    (Zero),
    .Jump    (Jump),
    .imm     (const_imm),
    .address (address),
    .next_pc (next_pc)
  );
  assign imem_req = state == REQ;
  assign imem_addr = pc;
  assign instr_valid = state == HOLD;
  always_comb begin
    timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    state_nx = state;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: state_nx = imem_ack ? HOLD : timed_out ? ERR : REQ;
      HOLD: state_nx = instr_ready ? REQ : HOLD;
      default: state_nx = ERR;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc <= RESET_VECTOR;
      instr <= '0;
      cnt <= '0;
      retire_count <= '0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == REQ) begin
        if (imem_ack) begin
          instr <= imem_rdata;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          if (timed_out) fetch_err <= 1'b1;
        end
      end
      if (state == HOLD && instr_ready) begin
        pc <= next_pc;
        retire_count <= retire_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized fetch traffic on three configurations against a PC/retire model
module tb_fetch_sequencer;
  localparam logic [31:0] RVS [3] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h3000_0010};
  localparam int TOS [3] = '{4, 0, 255};
  logic clk = 1'b0;
  logic [2:0] rst;
  logic imem_ack, instr_ready, Branch, Zero, Jump;
  logic [31:0] imem_rdata;
  logic [15:0] const_imm;
  logic [25:0] address;
  logic imem_req [3];
  logic instr_valid [3];
  logic fetch_err [3];
  logic [31:0] imem_addr [3];
  logic [31:0] instr [3];
  logic [31:0] pc [3];
  logic [31:0] retire_count [3];
  int checks = 0;
  int errors = 0;
  int sel = 0;
  logic [31:0] mpc, mret;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    fetch_sequencer #(.RESET_VECTOR(RVS[g]), .TIMEOUT(TOS[g]), .CNT_W(8)) u_dut (
      .clk          (clk),
      .reset        (rst[g]),
      .imem_req     (imem_req[g]),
      .imem_addr    (imem_addr[g]),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr        (instr[g]),
      .instr_valid  (instr_valid[g]),
      .instr_ready  (instr_ready),
      .Branch       (Branch),
      .Zero         (Zero),
      .Jump         (Jump),
      .const_imm    (const_imm),
      .address      (address),
      .pc           (pc[g]),
      .retire_count (retire_count[g]),
      .fetch_err    (fetch_err[g])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
    end
  endtask
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic br, z, j,
                                             input logic [15:0] c, input logic [25:0] a);
    logic [31:0] p4;
    int off;
    p4 = p + 32'd4;
    off = $signed(c);
    if (br && z) return p4 + 32'(off * 4);
    if (j) return (p4 & 32'hF000_0000) | (32'(a) * 4);
    return p4;
  endfunction
  task automatic do_reset(input int s);
    sel = s;
    rst = '0;
    imem_ack = 0;
    instr_ready = 0;
    @(negedge clk);
    check("rst_req", 32'(imem_req[sel]), 0);
    check("rst_valid", 32'(instr_valid[sel]), 0);
    check("rst_pc", pc[sel], RVS[sel]);
    check("rst_instr", instr[sel], 0);
    check("rst_retire", retire_count[sel], 0);
    check("rst_err", 32'(fetch_err[sel]), 0);
    mpc = RVS[sel];
    mret = 0;
    rst[sel] = 1'b1;
    @(negedge clk);
  endtask
  task automatic fetch_one(input int d, input int bp, input logic br, z, j,
                           input logic [15:0] c, input logic [25:0] a);
    logic [31:0] w;
    w = $urandom;
    for (int k = 0; k <= d; k++) begin
      check("req", 32'(imem_req[sel]), 1);
      check("addr", imem_addr[sel], mpc);
      check("valid_in_req", 32'(instr_valid[sel]), 0);
      imem_ack = (k == d);
      imem_rdata = (k == d) ? w : $urandom;
      @(negedge clk);
    end
    imem_ack = 0;
    for (int k = 0; k <= bp; k++) begin
      check("valid", 32'(instr_valid[sel]), 1);
      check("instr", instr[sel], w);
      check("pc_hold", pc[sel], mpc);
      check("req_in_hold", 32'(imem_req[sel]), 0);
      instr_ready = (k == bp);
      Branch = (k == bp) ? br : 1'($urandom);
      Zero = (k == bp) ? z : 1'($urandom);
      Jump = (k == bp) ? j : 1'($urandom);
      const_imm = (k == bp) ? c : 16'($urandom);
      address = (k == bp) ? a : 26'($urandom);
      @(negedge clk);
    end
    instr_ready = 0;
    mpc = model_next(mpc, br, z, j, c, a);
    mret++;
    check("retire", retire_count[sel], mret);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end
  initial begin
    rst = '0;
    {imem_ack, instr_ready, Branch, Zero, Jump} = '0;
    imem_rdata = 0;
    const_imm = 0;
    address = 0;
    do_reset(0);
    repeat (4) fetch_one(0, 0, 0, 0, 0, 16'h0, 26'h0);
    check("seq_addr", imem_addr[0], 32'd16);
    check("seq_retire", retire_count[0], 32'd4);
    fetch_one(0, 0, 0, 0, 1, 16'h0, 26'h40);
    check("jmp_0x100", imem_addr[0], 32'h100);
    fetch_one(1, 0, 1, 1, 0, 16'hFFFE, 26'h0);
    check("br_taken", imem_addr[0], 32'hFC);
    fetch_one(0, 0, 0, 0, 1, 16'h0, 26'h40);
    fetch_one(2, 0, 1, 0, 0, 16'hFFFE, 26'h0);
    check("br_not_taken", imem_addr[0], 32'h104);
    fetch_one(0, 5, 0, 0, 0, 16'h0, 26'h0);
    check("bp_addr", imem_addr[0], 32'h108);
    repeat (40)
      fetch_one($urandom_range(3), $urandom_range(2), 1'($urandom), 1'($urandom),
                1'($urandom), 16'($urandom), 26'($urandom));
    // timeout: four REQ cycles with no ack, then sticky ERR
    imem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      check("to_req", 32'(imem_req[0]), 1);
      check("to_err_early", 32'(fetch_err[0]), 0);
      @(negedge clk);
    end
    check("to_req_off", 32'(imem_req[0]), 0);
    check("to_err", 32'(fetch_err[0]), 1);
    check("to_valid", 32'(instr_valid[0]), 0);
    check("to_pc", pc[0], mpc);
    imem_ack = 1;
    repeat (3) @(negedge clk);
    imem_ack = 0;
    check("late_ack_err", 32'(fetch_err[0]), 1);
    check("late_ack_req", 32'(imem_req[0]), 0);
    check("late_ack_valid", 32'(instr_valid[0]), 0);
    check("late_ack_pc", pc[0], mpc);
    #2 rst[0] = 1'b0;
    #1;
    check("arst_err", 32'(fetch_err[0]), 0);
    check("arst_pc", pc[0], 32'h0);
    check("arst_retire", retire_count[0], 0);
    check("arst_req", 32'(imem_req[0]), 0);
    @(negedge clk);
    do_reset(2);
    fetch_one(0, 0, 0, 0, 1, 16'h0, 26'h40);
    check("jmp_hi", imem_addr[2], 32'h3000_0100);
    do_reset(2);
    fetch_one(0, 0, 1, 1, 1, 16'h1, 26'h40);
    check("br_over_jmp", imem_addr[2], 32'h3000_0018);
    do_reset(1);
    fetch_one(0, 0, 0, 0, 0, 16'h0, 26'h0);
    check("wrap", imem_addr[1], 32'h0);
    imem_ack = 1;
    imem_rdata = 32'hDEAD_BEEF;
    #3 rst[1] = 1'b0;
    @(negedge clk);
    imem_ack = 0;
    check("mid_rst_instr", instr[1], 0);
    check("mid_rst_valid", 32'(instr_valid[1]), 0);
    check("mid_rst_pc", pc[1], 32'hFFFF_FFFC);
    check("mid_rst_retire", retire_count[1], 0);
    rst[1] = 1'b1;
    @(negedge clk);
    repeat (300) @(negedge clk);
    check("no_to_req", 32'(imem_req[1]), 1);
    check("no_to_err", 32'(fetch_err[1]), 0);
    check("no_to_addr", imem_addr[1], 32'hFFFF_FFFC);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
